// File: rtl/ram_burst_reader_if.sv
// Bundle of the burst-reader signals: request/status, RAM read port and
// the valid/ready output stream. The reader uses the master view; the
// environment (RAM, consumer, requester) uses the slave view.
interface ram_burst_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   len;
  logic                  busy;
  logic                  done_tick;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_q;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  start, base_addr, len, ram_q, m_ready,
    output busy, done_tick, ram_addr, m_data, m_valid
  );

  modport slave (
    output start, base_addr, len, ram_q, m_ready,
    input  busy, done_tick, ram_addr, m_data, m_valid
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read master for a single-port synchronous RAM. Reads `len` words
// from `base_addr` (wrapping at the top of memory) and streams them out
// through a 2-entry FIFO. A credit check (buffer entries + read in flight)
// guarantees the buffer always has room for the RAM word returning one
// cycle after each issued address, so the capture never needs a stall.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ram_burst_reader_if.master   bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [ADDR_WIDTH:0]   remain_q, remain_d;
  logic                  inflight_q, inflight_d;
  logic                  zero_done_q, zero_done_d;
  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [DATA_WIDTH-1:0] buf_d [2];
  logic                  wr_idx_q, wr_idx_d;
  logic                  rd_idx_q, rd_idx_d;
  logic [1:0]            count_q, count_d;

  logic                  pop;
  logic                  issue;
  logic                  last_pop;
  logic [2:0]            occ;

  // Handshake, credit check and next-state computation for all registers.
  always_comb begin
    pop      = (count_q != 2'd0) && bus.m_ready;
    occ      = {1'b0, count_q} + {2'b00, inflight_q};
    // A slot counts as free if it is empty now, or the head leaves this cycle.
    issue    = (state_q == ISSUE) && ((occ < 3'd2) || ((occ == 3'd2) && pop));
    last_pop = (state_q == DRAIN) && pop && (count_q == 2'd1) && !inflight_q;

    state_d     = state_q;
    ram_addr_d  = ram_addr_q;
    remain_d    = remain_q;
    zero_done_d = 1'b0;
    inflight_d  = issue;
    buf_d       = buf_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            zero_done_d = 1'b1;
          end else begin
            state_d    = ISSUE;
            ram_addr_d = bus.base_addr;
            remain_d   = bus.len;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          remain_d = remain_q - (ADDR_WIDTH+1)'(1);
          // Keep the address of the final read on the bus afterwards.
          if (remain_q == (ADDR_WIDTH+1)'(1)) begin
            state_d = DRAIN;
          end else begin
            ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (last_pop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The word addressed last cycle is on ram_q now; the credit rule
    // guarantees a free slot for it.
    if (inflight_q) begin
      buf_d[wr_idx_q] = bus.ram_q;
      wr_idx_d        = ~wr_idx_q;
    end
    if (pop) begin
      rd_idx_d = ~rd_idx_q;
    end
    count_d = count_q + {1'b0, inflight_q} - {1'b0, pop};
  end

  // Control state: FSM, address pointer, issue counter and FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      remain_q    <= '0;
      inflight_q  <= 1'b0;
      zero_done_q <= 1'b0;
      wr_idx_q    <= 1'b0;
      rd_idx_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      remain_q    <= remain_d;
      inflight_q  <= inflight_d;
      zero_done_q <= zero_done_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; cleared on reset so m_data reads zero while empty.
  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        buf_q[gi] <= '0;
      end else begin
        buf_q[gi] <= buf_d[gi];
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done_tick = zero_done_q | last_pop;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.m_valid   = (count_q != 2'd0);
  assign bus.m_data    = buf_q[rd_idx_q];

endmodule

// File: tb/tb_ram_burst_reader.sv
// Scoreboard bench for ram_burst_reader: a behavioural RAM, randomized
// backpressure, expected words queued at request time and checked by an
// independent monitor on every transfer.
module tb_ram_burst_reader;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  ram_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Synchronous RAM: registered address, data one cycle later.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) bus.ram_q <= mem[bus.ram_addr];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];
  int popped = 0;
  int done_seen = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Consumer ready driver.
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, stability under backpressure, idle quiet.
  initial begin
    logic prev_hold;
    logic [DW-1:0] prev_data;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", 32'(bus.m_valid), 32'd1);
          check("hold_data", 32'(bus.m_data), 32'(prev_data));
        end
        if (!bus.busy) check("valid_idle", 32'(bus.m_valid), 32'd0);
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_word got %0h expected none", bus.m_data);
          end else begin
            check("data", 32'(bus.m_data), 32'(exp_q.pop_front()));
          end
          popped++;
        end
        if (bus.done_tick) done_seen++;
        prev_hold = bus.m_valid && !bus.m_ready;
        prev_data = bus.m_data;
      end
    end
  end

  // Pulse start for one cycle; optionally queue the expected words.
  task automatic start_burst(input int base, input int len, input bit push);
    repeat (2) @(posedge clk);
    #1;
    bus.start     = 1'b1;
    bus.base_addr = AW'(base);
    bus.len       = (AW+1)'(len);
    if (push) begin
      for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % DEPTH]);
    end
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.base_addr = AW'($urandom);
    bus.len       = (AW+1)'($urandom);
  endtask

  // Wait for done_tick (bounded), then check the burst fully drained.
  task automatic wait_done(input string name, input int budget, input logic [DW-1:0] last_word,
                           output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if (bus.done_tick) begin
        got = 1'b1;
        check({name, "_last_word"}, 32'(bus.m_data), 32'(last_word));
        break;
      end
    end
    check({name, "_done"}, 32'(got), 32'd1);
    @(negedge clk);
    check({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    $display("burst %s finished after %0d cycles, checks %0d", name, cycles, checks);
  endtask

  // Basic burst with exact latency and throughput checks.
  task automatic basic_burst(input string name);
    int cyc;
    ready_mode = 0;
    start_burst(4, 5, 1'b1);
    @(negedge clk);
    check({name, "_lat1"}, 32'(bus.m_valid), 32'd0);
    check({name, "_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    check({name, "_lat2"}, 32'(bus.m_valid), 32'd0);
    @(negedge clk);
    check({name, "_first_valid"}, 32'(bus.m_valid), 32'd1);
    check({name, "_first_data"}, 32'(bus.m_data), 32'h14);
    wait_done(name, 50, 8'h18, cyc);
    check({name, "_cycles"}, 32'(cyc), 32'd4);
  endtask

  initial begin
    int cyc;
    int base;
    int len;
    int d0;
    int p0;
    logic [AW-1:0] saved_addr;

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 'h10);
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.len = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_valid", 32'(bus.m_valid), 32'd0);
    check("rst_done", 32'(bus.done_tick), 32'd0);
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_data", 32'(bus.m_data), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    basic_burst("basic");

    // Address wrap at the top of memory.
    start_burst(1022, 4, 1'b1);
    wait_done("wrap", 50, mem[1], cyc);

    // Backpressure bursts.
    ready_mode = 1;
    base = int'($urandom_range(0, DEPTH - 1));
    start_burst(base, 8, 1'b1);
    wait_done("bp8", 400, mem[(base + 7) % DEPTH], cyc);
    for (int k = 0; k < 6; k++) begin
      base = int'($urandom_range(0, DEPTH - 1));
      len  = int'($urandom_range(1, 40));
      start_burst(base, len, 1'b1);
      wait_done("rand", 800, mem[(base + len - 1) % DEPTH], cyc);
    end

    // Full stall: only two reads may be outstanding.
    ready_mode = 2;
    start_burst(100, 6, 1'b1);
    repeat (20) @(negedge clk);
    check("stall_valid", 32'(bus.m_valid), 32'd1);
    check("stall_data", 32'(bus.m_data), 32'(mem[100]));
    check("stall_addr", 32'(bus.ram_addr), 32'd102);
    check("stall_busy", 32'(bus.busy), 32'd1);
    ready_mode = 0;
    wait_done("stall", 100, mem[105], cyc);

    // Zero-length request.
    saved_addr = bus.ram_addr;
    start_burst(0, 0, 1'b1);
    @(negedge clk);
    check("len0_done", 32'(bus.done_tick), 32'd1);
    check("len0_busy", 32'(bus.busy), 32'd0);
    check("len0_valid", 32'(bus.m_valid), 32'd0);
    check("len0_addr", 32'(bus.ram_addr), 32'(saved_addr));
    @(negedge clk);
    check("len0_done_off", 32'(bus.done_tick), 32'd0);
    $display("burst len0 finished, checks %0d", checks);

    // Start while busy must be ignored.
    d0 = done_seen;
    start_burst(50, 10, 1'b1);
    start_burst(0, 3, 1'b0);
    wait_done("busy_start", 100, mem[59], cyc);
    repeat (10) @(negedge clk);
    check("busy_start_done_count", 32'(done_seen - d0), 32'd1);
    check("busy_start_no_extra", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a burst.
    p0 = popped;
    start_burst(200, 10, 1'b1);
    for (int i = 0; i < 50 && popped < p0 + 3; i++) @(negedge clk);
    check("mid_reset_progress", 32'(popped - p0 >= 3), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_reset_valid", 32'(bus.m_valid), 32'd0);
    check("mid_reset_busy", 32'(bus.busy), 32'd0);
    check("mid_reset_done", 32'(bus.done_tick), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    basic_burst("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side master for the single-port synchronous RAM (registered address, data on q one cycle after the address edge).
- On `start`, reads `len` consecutive words from `base_addr` and streams them in order on a valid/ready output.
- A 2-entry output buffer absorbs the fixed 1-cycle RAM read latency and downstream backpressure without losing a word.
- Sits between the RAM and any consumer (UART TX, VGA line fetch, DMA).

Parameters:
- DATA_WIDTH, 8: RAM word width in bits.
- ADDR_WIDTH, 10: RAM address width; depth is 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first read address; captured on accepted start.
- len  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH; captured on accepted start.
- busy  out  1  high from accepted start until the cycle done_tick is asserted.
- done_tick  out  1  one-cycle pulse when the burst completes.
- ram_addr  out  ADDR_WIDTH  address to the RAM; `ram_we` is tied 0 by the integrator.
- ram_q  in  DATA_WIDTH  RAM read data; valid the cycle after ram_addr was sampled.
- m_data  out  DATA_WIDTH  output word.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer accepts; transfer occurs when m_valid && m_ready.

Behaviour:
- Reset (async assert, sync release): state IDLE, busy=0, done_tick=0, m_valid=0, m_data=0, ram_addr=0, buffer empty, no read in flight.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE -> ISSUE on start with len!=0.
  - IDLE -> IDLE on start with len==0; done_tick pulses the next cycle; busy stays 0; no RAM read.
  - ISSUE -> DRAIN in the cycle the last read is issued.
  - DRAIN -> IDLE in the cycle the last word transfers; done_tick pulses that same cycle.
- start while busy is ignored; base_addr and len changes mid-burst are ignored.
- Read issue:
  - `issue` is an internal strobe.
  - In cycle t, ram_addr = current read pointer. If issue, ram_q is captured into the buffer at the end of cycle t+1 unconditionally.
  - The read pointer increments modulo 2**ADDR_WIDTH, wrapping 2**ADDR_WIDTH-1 -> 0. The remaining-issue counter decrements.
- Credit rule (guarantees room for the unconditional capture):
  - occ = buffer entries + reads in flight (0..2).
  - issue = (state==ISSUE) && (occ<2 || (occ==2 && pop this cycle)).
- Throughput: with m_ready held high, 1 word/cycle sustained.
- Latency: first m_valid is 2 cycles after the accepted start edge (start sampled at edge 0; first issue cycle 1; data valid cycle 2).
- Buffer: 2-entry FIFO, in order; m_data/m_valid driven from the head entry.
  - Simultaneous capture and pop on a non-empty buffer is legal; count is unchanged.
  - With an empty buffer, a capture makes m_valid rise the following cycle. No combinational ram_q -> m_data path.
- AXI-style stability: while m_valid && !m_ready, m_data and m_valid hold.
- m_valid never asserts outside a burst; no word is ever dropped or duplicated.
- len == 2**ADDR_WIDTH reads the entire RAM once, wrapping if base_addr!=0.
- ram_addr holds its last value when not issuing; reads with no issue are not captured.
- Reset mid-burst: immediate return to reset values; buffer contents and in-flight read discarded; no done_tick.

Test Plan:
- Basic burst, RAM preloaded ram[i]=i+8'h10, m_ready=1: start, base_addr=4, len=5 -> m_data 14,15,16,17,18 on 5 consecutive cycles; first valid 2 cycles after start; done_tick on the 18 transfer; busy low the following cycle.
- Wrap, ADDR_WIDTH=10: base_addr=1022, len=4 -> ram_addr sequence 1022,1023,0,1 -> data from ram[1022],ram[1023],ram[0],ram[1] in order.
- Backpressure, len=8, m_ready random ~50%:
  - outputs exactly ram[base..base+7] in order, no drops or duplicates;
  - m_data stable whenever valid && !ready;
  - occ never exceeds 2.
- Full stall: m_ready=0 for 20 cycles after start, len=6 -> exactly 2 reads issued; m_valid=1 holding the first word. Release m_ready -> remaining 4 reads issue and all 6 words are delivered.
- len=0 and busy-start: start with len=0 -> done_tick 1 cycle later, no RAM read, m_valid stays 0. During a len=10 burst pulse start with base_addr=0 -> ignored, burst completes unchanged.
- Reset mid-burst: assert reset_n=0 after 3 of 10 words -> m_valid, busy, done_tick go 0 asynchronously. A new burst after release behaves as in the basic burst, with no stale data.
